keypoint_topk_buffer: RTL and testbench
=======================================

Name: keypoint_topk_buffer

Overview:
Parametrised successor of the single-frame keypoint buffer. It collects a stream of keypoints (coordinates, score, descriptor) for one frame and keeps only the DEPTH highest-scoring ones, sorted in descending score order. At frame end it drains them over a valid/ready handshake to the matcher.
Sits between the FAST/BRIEF descriptor pipeline and the feature-matching stage.

Parameters:
DEPTH, 16, number of retained keypoints (2..64)
COOR_W, 10, width of each coordinate
SCORE_W, 8, score width (unsigned)
DESC_W, 256, descriptor width
NMS_RADIUS, 2, Chebyshev radius for optional suppression

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous active-high reset
i_valid  input  1  input keypoint valid
o_in_ready  output  1  buffer accepts input (FILL state)
i_coor_x  input  COOR_W  keypoint x
i_coor_y  input  COOR_W  keypoint y
i_score  input  SCORE_W  keypoint score
i_descriptor  input  DESC_W  keypoint descriptor
i_frame_end  input  1  one-cycle pulse: frame finished, begin drain
o_valid  output  1  output keypoint valid
i_ready  input  1  downstream accepts output
o_coor_x  output  COOR_W  head entry x
o_coor_y  output  COOR_W  head entry y
o_score  output  SCORE_W  head entry score
o_descriptor  output  DESC_W  head entry descriptor
o_count  output  $clog2(DEPTH+1)  entries currently stored
o_drop_cnt  output  16  keypoints discarded this frame, saturating at 65535
o_done  output  1  one-cycle pulse when drain completes

Behaviour:
- Reset: state=FILL, all entries zeroed, o_count=0, o_drop_cnt=0, o_valid=0, o_done=0, o_in_ready=1.
- States: FILL, DRAIN, DONE. FILL->DRAIN on i_frame_end. DRAIN->DONE on the handshake that empties the buffer. DONE->FILL unconditionally next cycle; o_done=1 only in DONE.
- FILL: o_in_ready=1, o_valid=0. The keypoint is accepted when i_valid=1. Entries [0..o_count-1] are kept sorted with entry 0 the highest score.
- Insertion position p = number of stored entries with score >= i_score, so ties keep arrival order and the older entry stays ahead. Entries p..end shift down by one and the new entry is written at p, all in one cycle. Result is visible the next cycle.
- Not full: o_count increments.
- Full and p<DEPTH: the last entry is evicted, o_count is unchanged, o_drop_cnt increments.
- Full and p==DEPTH (i_score <= minimum): the input is dropped, o_drop_cnt increments, storage is unchanged.
- i_valid and i_frame_end in the same cycle: the keypoint is inserted first, then the state moves to DRAIN.
- DRAIN: o_in_ready=0 and i_valid is ignored (not counted as a drop). o_valid=1 from the first DRAIN cycle while o_count>0, and the outputs show entry 0.
- On o_valid&&i_ready: entries shift up by one, the vacated tail is zeroed, o_count decrements. Outputs are stable while o_valid&&!i_ready.
- i_frame_end with o_count=0: the state passes through DRAIN for one cycle with o_valid=0, then DONE.
- i_frame_end during DRAIN or DONE is ignored.
- Entering FILL from DONE clears o_drop_cnt; entries are already zero.
- i_rst mid-drain or mid-fill aborts immediately to the reset state; no o_done is issued.
- Output data ports are zero whenever o_count=0.

Optional Feature:
KEYBUF_NMS_EN
- Defined: in FILL, an input is rejected (o_drop_cnt increments, no insertion) if any stored entry has |dx|<=NMS_RADIUS, |dy|<=NMS_RADIUS and score >= i_score.
- If instead the nearby stored entry has a lower score, that entry is removed and the new entry inserted in the same cycle; o_count is unchanged.
- If several stored entries are nearby, only the lowest-index one is removed.
- Not defined: no spatial check; behaviour exactly as above.

Test Plan:
- DEPTH=4: insert scores 10,30,20,40, then i_frame_end, i_ready=1 -> drained scores 40,30,20,10; o_done pulses the cycle after the 4th handshake; o_count ends at 0.
- DEPTH=4 full with 40,30,20,10: insert 25 -> contents 40,30,25,20, o_drop_cnt=1; then insert 5 -> unchanged, o_drop_cnt=2.
- Equal scores 50 at (1,1) then 50 at (9,9) -> drain order (1,1) then (9,9).
- Drain with i_ready toggling 1,0,0,1 -> outputs held during stalls, no entry lost or duplicated; i_valid during DRAIN -> o_in_ready=0, o_drop_cnt unchanged.
- i_frame_end on an empty buffer -> o_valid never asserts, o_done pulses 2 cycles later; i_rst asserted mid-drain -> o_count=0, o_valid=0 next cycle, no o_done.
- KEYBUF_NMS_EN, NMS_RADIUS=2: store 60@(10,10), insert 50@(11,12) -> rejected, o_drop_cnt=1; insert 70@(12,9) -> replaces it, o_count=1, head score 70.

Source files
------------

// File: rtl/keypoint_topk_buffer.sv
// keypoint_topk_buffer
// Collects one frame of keypoints and keeps the DEPTH highest-scoring ones,
// sorted by descending score (entry 0 = best). On i_frame_end the entries are
// drained head-first over a valid/ready handshake, followed by a one-cycle o_done.
//
// Optional feature macro: KEYBUF_NMS_EN
//   When defined, an incoming keypoint is spatially checked against the stored
//   entries (Chebyshev radius NMS_RADIUS). It is rejected if a nearby entry scores
//   at least as high; otherwise the lowest-index nearby entry is replaced.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_valid / o_in_ready   input keypoint handshake (ready only while filling)
//   i_coor_x/y, i_score,   input keypoint fields
//   i_descriptor
//   i_frame_end            one-cycle pulse: start draining
//   o_valid / i_ready      output handshake, o_* data show entry 0
//   o_count                entries currently stored
//   o_drop_cnt             saturating count of discarded keypoints this frame
//   o_done                 one-cycle pulse after the drain completes
module keypoint_topk_buffer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned COOR_W     = 10,
  parameter int unsigned SCORE_W    = 8,
  parameter int unsigned DESC_W     = 256,
  parameter int unsigned NMS_RADIUS = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_in_ready,
  input  logic [COOR_W-1:0]            i_coor_x,
  input  logic [COOR_W-1:0]            i_coor_y,
  input  logic [SCORE_W-1:0]           i_score,
  input  logic [DESC_W-1:0]            i_descriptor,
  input  logic                         i_frame_end,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [COOR_W-1:0]            o_coor_x,
  output logic [COOR_W-1:0]            o_coor_y,
  output logic [SCORE_W-1:0]           o_score,
  output logic [DESC_W-1:0]            o_descriptor,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [15:0]                  o_drop_cnt,
  output logic                         o_done
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [COOR_W-1:0] RADIUS_C = COOR_W'(NMS_RADIUS);

`ifdef KEYBUF_NMS_EN
  localparam bit NmsEn = 1'b1;
`else
  localparam bit NmsEn = 1'b0;
`endif

  typedef enum logic [1:0] {StFill, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [15:0]         drop_q, drop_d;

  logic [COOR_W-1:0]   x_q     [DEPTH];
  logic [COOR_W-1:0]   x_d     [DEPTH];
  logic [COOR_W-1:0]   y_q     [DEPTH];
  logic [COOR_W-1:0]   y_d     [DEPTH];
  logic [SCORE_W-1:0]  score_q [DEPTH];
  logic [SCORE_W-1:0]  score_d [DEPTH];
  logic [DESC_W-1:0]   desc_q  [DEPTH];
  logic [DESC_W-1:0]   desc_d  [DEPTH];

  int unsigned         cnt;       // count_q as an integer
  int unsigned         ins_pos;   // entries with score >= i_score
  int unsigned         ins_end;   // last slot touched by the shift-down
  int unsigned         near_idx;  // lowest-index nearby entry
  logic                near_hit;
  logic                near_block;
  logic                do_insert;
  logic                drop_inc;
  logic [COOR_W-1:0]   dx, dy;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    drop_d     = drop_q;
    x_d        = x_q;
    y_d        = y_q;
    score_d    = score_q;
    desc_d     = desc_q;
    cnt        = int'(count_q);
    ins_pos    = 0;
    ins_end    = 0;
    near_idx   = 0;
    near_hit   = 1'b0;
    near_block = 1'b0;
    do_insert  = 1'b0;
    drop_inc   = 1'b0;
    dx         = '0;
    dy         = '0;

    // Only stored entries take part; the list is sorted, so the entries with
    // score >= i_score form a prefix and ins_pos is its length.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i < cnt) begin
        if (score_q[i] >= i_score) ins_pos = ins_pos + 1;
        dx = (x_q[i] > i_coor_x) ? x_q[i] - i_coor_x : i_coor_x - x_q[i];
        dy = (y_q[i] > i_coor_y) ? y_q[i] - i_coor_y : i_coor_y - y_q[i];
        if (dx <= RADIUS_C && dy <= RADIUS_C) begin
          if (score_q[i] >= i_score) near_block = 1'b1;
          if (!near_hit) begin
            near_hit = 1'b1;
            near_idx = i;
          end
        end
      end
    end

    unique case (state_q)
      StFill: begin
        if (i_valid) begin
          if (NmsEn && near_block) begin
            drop_inc = 1'b1;
          end else if (NmsEn && near_hit) begin
            // Nearby entry scores lower, so it sits at or after ins_pos.
            do_insert = 1'b1;
            ins_end   = near_idx;
          end else if (cnt < DEPTH) begin
            do_insert = 1'b1;
            ins_end   = cnt;
            count_d   = count_q + CNT_W'(1);
          end else if (ins_pos < DEPTH) begin
            do_insert = 1'b1;
            ins_end   = DEPTH - 1;
            drop_inc  = 1'b1;
          end else begin
            drop_inc = 1'b1;
          end
        end
        // Slots before ins_pos keep their entry, slots ins_pos+1..ins_end take
        // their predecessor, and the slot at ins_end's old contents is lost.
        if (do_insert) begin
          for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i == ins_pos) begin
              x_d[i]     = i_coor_x;
              y_d[i]     = i_coor_y;
              score_d[i] = i_score;
              desc_d[i]  = i_descriptor;
            end else if (i > ins_pos && i <= ins_end) begin
              x_d[i]     = x_q[i-1];
              y_d[i]     = y_q[i-1];
              score_d[i] = score_q[i-1];
              desc_d[i]  = desc_q[i-1];
            end
          end
        end
        if (i_frame_end) state_d = StDrain;
      end

      StDrain: begin
        if (count_q == '0) begin
          state_d = StDone;
        end else if (i_ready) begin
          for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i < DEPTH - 1) begin
              x_d[i]     = x_q[i+1];
              y_d[i]     = y_q[i+1];
              score_d[i] = score_q[i+1];
              desc_d[i]  = desc_q[i+1];
            end else begin
              x_d[i]     = '0;
              y_d[i]     = '0;
              score_d[i] = '0;
              desc_d[i]  = '0;
            end
          end
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) state_d = StDone;
        end
      end

      StDone: begin
        state_d = StFill;
        drop_d  = '0;
      end

      default: state_d = StFill;
    endcase

    if (drop_inc && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StFill;
      count_q <= '0;
      drop_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        score_q[i] <= '0;
        desc_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      x_q     <= x_d;
      y_q     <= y_d;
      score_q <= score_d;
      desc_q  <= desc_d;
    end
  end

  // Unused slots are always zero, so entry 0 reads as zero when empty.
  always_comb begin
    o_in_ready   = (state_q == StFill);
    o_valid      = (state_q == StDrain) && (count_q != '0);
    o_done       = (state_q == StDone);
    o_coor_x     = x_q[0];
    o_coor_y     = y_q[0];
    o_score      = score_q[0];
    o_descriptor = desc_q[0];
    o_count      = count_q;
    o_drop_cnt   = drop_q;
  end

endmodule

// File: tb/tb_keypoint_topk_buffer.sv
module tb_keypoint_topk_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = 10;
  localparam int SW    = 8;
  localparam int DW    = 64;
  localparam int NW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          i_rst, i_valid, i_frame_end, i_ready;
  logic [CW-1:0] i_coor_x, i_coor_y;
  logic [SW-1:0] i_score;
  logic [DW-1:0] i_descriptor;
  logic          o_in_ready, o_valid, o_done;
  logic [CW-1:0] o_coor_x, o_coor_y;
  logic [SW-1:0] o_score;
  logic [DW-1:0] o_descriptor;
  logic [NW-1:0] o_count;
  logic [15:0]   o_drop_cnt;

  keypoint_topk_buffer #(
    .DEPTH(DEPTH), .COOR_W(CW), .SCORE_W(SW), .DESC_W(DW), .NMS_RADIUS(2)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_in_ready(o_in_ready),
    .i_coor_x(i_coor_x), .i_coor_y(i_coor_y), .i_score(i_score),
    .i_descriptor(i_descriptor), .i_frame_end(i_frame_end), .o_valid(o_valid),
    .i_ready(i_ready), .o_coor_x(o_coor_x), .o_coor_y(o_coor_y), .o_score(o_score),
    .o_descriptor(o_descriptor), .o_count(o_count), .o_drop_cnt(o_drop_cnt),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [SW-1:0] s;
    logic [DW-1:0] d;
  } kp_t;

  // Reference: a sorted list of the best DEPTH keypoints plus a drop counter.
  kp_t mq[$];
  int  m_drop = 0;
  int  n_cmp  = 0;
  int  n_err  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_insert(input kp_t k);
    int p = 0;
    int ni = -1;
    bit blk = 0;
`ifdef KEYBUF_NMS_EN
    foreach (mq[i]) begin
      int dx = int'(mq[i].x) - int'(k.x);
      int dy = int'(mq[i].y) - int'(k.y);
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      if (dx <= 2 && dy <= 2) begin
        if (mq[i].s >= k.s) blk = 1;
        if (ni < 0) ni = i;
      end
    end
`endif
    if (blk) begin
      if (m_drop < 65535) m_drop++;
      return;
    end
    if (ni >= 0) mq.delete(ni);
    foreach (mq[i]) if (mq[i].s >= k.s) p++;
    mq.insert(p, k);
    if (mq.size() > DEPTH) begin
      void'(mq.pop_back());
      if (m_drop < 65535) m_drop++;
    end
  endtask

  task automatic drive_kp(input int x, input int y, input int s, input bit fe);
    kp_t k;
    k.x = CW'(x);
    k.y = CW'(y);
    k.s = SW'(s);
    k.d = {$urandom, $urandom};
    i_valid      = 1'b1;
    i_coor_x     = k.x;
    i_coor_y     = k.y;
    i_score      = k.s;
    i_descriptor = k.d;
    i_frame_end  = fe;
    step();
    i_valid     = 1'b0;
    i_frame_end = 1'b0;
    model_insert(k);
  endtask

  task automatic frame_end_only();
    i_frame_end = 1'b1;
    step();
    i_frame_end = 1'b0;
  endtask

  // Called one cycle after i_frame_end was sampled (DUT now in DRAIN).
  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic run_drain(input int mode);
    int cyc = 0;
    bit rdy;
    if (mq.size() == 0) begin
      n_cmp++;
      if (o_valid !== 1'b0 || o_done !== 1'b0 || o_in_ready !== 1'b0)
        $display("FAIL empty_drain: valid=%b done=%b in_ready=%b want 0 0 0",
                 o_valid, o_done, o_in_ready);
      if (o_valid !== 1'b0 || o_done !== 1'b0 || o_in_ready !== 1'b0) n_err++;
      step();
    end else begin
      while (mq.size() > 0 && cyc < 200) begin
        rdy = (mode == 0) ? 1'b1 :
              (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom_range(0, 1));
        i_ready = rdy;
        n_cmp++;
        if (o_valid !== 1'b1 || o_score !== mq[0].s || o_coor_x !== mq[0].x ||
            o_coor_y !== mq[0].y || o_descriptor !== mq[0].d ||
            o_count !== NW'(mq.size()) || o_in_ready !== 1'b0 || o_done !== 1'b0 ||
            o_drop_cnt !== 16'(m_drop)) begin
          n_err++;
          $display("FAIL drain_head cyc=%0d: got v=%b s=%0d x=%0d y=%0d cnt=%0d drop=%0d",
                   cyc, o_valid, o_score, o_coor_x, o_coor_y, o_count, o_drop_cnt);
          $display("     want v=1 s=%0d x=%0d y=%0d cnt=%0d drop=%0d",
                   mq[0].s, mq[0].x, mq[0].y, mq.size(), m_drop);
        end
        step();
        cyc++;
        if (rdy) void'(mq.pop_front());
      end
      i_ready = 1'b0;
      if (cyc >= 200) begin
        n_err++;
        $display("FAIL drain_timeout: %0d entries left, want 0", mq.size());
      end
    end
    i_valid = 1'b0;
    n_cmp++;
    if (o_done !== 1'b1 || o_count !== '0 || o_valid !== 1'b0 || o_score !== '0) begin
      n_err++;
      $display("FAIL done_pulse: done=%b cnt=%0d valid=%b score=%0d want 1 0 0 0",
               o_done, o_count, o_valid, o_score);
    end
    step();
    m_drop = 0;
    n_cmp++;
    if (o_done !== 1'b0 || o_in_ready !== 1'b1 || o_drop_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL back_to_fill: done=%b in_ready=%b drop=%0d want 0 1 0",
               o_done, o_in_ready, o_drop_cnt);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    mq.delete();
    m_drop = 0;
    n_cmp++;
    if (o_count !== '0 || o_drop_cnt !== '0 || o_valid !== 1'b0 || o_done !== 1'b0 ||
        o_in_ready !== 1'b1 || o_score !== '0 || o_descriptor !== '0) begin
      n_err++;
      $display("FAIL reset: cnt=%0d drop=%0d valid=%b done=%b in_ready=%b score=%0d",
               o_count, o_drop_cnt, o_valid, o_done, o_in_ready, o_score);
    end
  endtask

  task automatic test_sorted_drain();
    int sc[4] = '{10, 30, 20, 40};
    foreach (sc[i]) drive_kp($urandom_range(0, 1023), $urandom_range(0, 1023), sc[i], 1'b0);
    n_cmp++;
    if (o_count !== NW'(4) || mq[0].s !== 8'd40 || mq[3].s !== 8'd10) begin
      n_err++;
      $display("FAIL sorted_fill: cnt=%0d want 4", o_count);
    end
    frame_end_only();
    run_drain(0);
  endtask

  task automatic test_evict();
    int sc[4] = '{40, 30, 20, 10};
    foreach (sc[i]) drive_kp(100 * i, 100 * i, sc[i], 1'b0);
    drive_kp(700, 700, 25, 1'b0);
    n_cmp++;
    if (o_drop_cnt !== 16'd1 || o_count !== NW'(4) || mq[2].s !== 8'd25) begin
      n_err++;
      $display("FAIL evict: drop=%0d cnt=%0d want 1 4", o_drop_cnt, o_count);
    end
    drive_kp(800, 800, 5, 1'b0);
    n_cmp++;
    if (o_drop_cnt !== 16'd2 || o_count !== NW'(4)) begin
      n_err++;
      $display("FAIL drop_min: drop=%0d cnt=%0d want 2 4", o_drop_cnt, o_count);
    end
    frame_end_only();
    run_drain(0);
  endtask

  task automatic test_ties();
    drive_kp(1, 1, 50, 1'b0);
    drive_kp(9, 9, 50, 1'b0);
    frame_end_only();
    n_cmp++;
    if (o_coor_x !== 10'd1 || o_coor_y !== 10'd1) begin
      n_err++;
      $display("FAIL tie_order: head=(%0d,%0d) want (1,1)", o_coor_x, o_coor_y);
    end
    run_drain(0);
  endtask

  task automatic test_stall_and_ignore();
    for (int i = 0; i < 4; i++)
      drive_kp($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 255), 1'b0);
    frame_end_only();
    // Offer input throughout the drain: it must be refused and not counted.
    i_valid      = 1'b1;
    i_score      = 8'hFF;
    i_coor_x     = 10'd3;
    i_coor_y     = 10'd3;
    i_descriptor = '1;
    i_frame_end  = 1'b1;
    step();
    i_frame_end = 1'b0;
    i_ready     = 1'b0;
    n_cmp++;
    if (o_in_ready !== 1'b0 || o_count !== NW'(4) || o_drop_cnt !== 16'(m_drop)) begin
      n_err++;
      $display("FAIL drain_ignore: in_ready=%b cnt=%0d drop=%0d want 0 4 %0d",
               o_in_ready, o_count, o_drop_cnt, m_drop);
    end
    run_drain(1);
  endtask

  task automatic test_empty_frame();
    frame_end_only();
    run_drain(0);
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) drive_kp(50 * i, 7, 20 + i, 1'b0);
    frame_end_only();
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    i_rst   = 1'b1;
    step();
    i_rst = 1'b0;
    mq.delete();
    m_drop = 0;
    n_cmp++;
    if (o_count !== '0 || o_valid !== 1'b0 || o_done !== 1'b0 || o_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_drain: cnt=%0d valid=%b done=%b in_ready=%b want 0 0 0 1",
               o_count, o_valid, o_done, o_in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (o_done !== 1'b0 || o_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rst_no_done: done=%b valid=%b want 0 0", o_done, o_valid);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 8; f++) begin
      int  n = $urandom_range(0, 10);
      bit  fe_seen = 0;
      for (int k = 0; k < n; k++) begin
        bit fe = (k == n - 1) && ($urandom_range(0, 1) == 1);
        drive_kp($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 15), fe);
        fe_seen = fe;
        n_cmp++;
        if (o_count !== NW'(mq.size()) || o_drop_cnt !== 16'(m_drop)) begin
          n_err++;
          $display("FAIL rand_fill f=%0d k=%0d: cnt=%0d drop=%0d want %0d %0d",
                   f, k, o_count, o_drop_cnt, mq.size(), m_drop);
        end
      end
      if (!fe_seen) frame_end_only();
      run_drain(2);
    end
  endtask

`ifdef KEYBUF_NMS_EN
  task automatic test_nms();
    drive_kp(10, 10, 60, 1'b0);
    drive_kp(11, 12, 50, 1'b0);
    n_cmp++;
    if (o_drop_cnt !== 16'd1 || o_count !== NW'(1)) begin
      n_err++;
      $display("FAIL nms_reject: drop=%0d cnt=%0d want 1 1", o_drop_cnt, o_count);
    end
    drive_kp(12, 9, 70, 1'b0);
    n_cmp++;
    if (o_drop_cnt !== 16'd1 || o_count !== NW'(1)) begin
      n_err++;
      $display("FAIL nms_replace: drop=%0d cnt=%0d want 1 1", o_drop_cnt, o_count);
    end
    frame_end_only();
    n_cmp++;
    if (o_score !== 8'd70) begin
      n_err++;
      $display("FAIL nms_head: score=%0d want 70", o_score);
    end
    run_drain(0);
  endtask
`endif

  initial begin
    i_rst        = 1'b1;
    i_valid      = 1'b0;
    i_frame_end  = 1'b0;
    i_ready      = 1'b0;
    i_coor_x     = '0;
    i_coor_y     = '0;
    i_score      = '0;
    i_descriptor = '0;
    test_reset();
    test_sorted_drain();
    test_evict();
    test_ties();
    test_stall_and_ignore();
    test_empty_frame();
    test_reset_mid_drain();
    test_random_frames();
`ifdef KEYBUF_NMS_EN
    test_nms();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
